dut_result_checker: RTL
=======================

# dut_result_checker

Sequential consumer placed directly downstream of the combinational `dut` vector stage. It accepts the 80-bit `out` word per applied 150-bit stimulus over a valid/ready stream and compares each beat against an expected word. It counts mismatches, records the first failure, and compacts every accepted result into a MISR signature. This replaces the single-shot `$display` and `$writememb` dump with a hardware-checkable multi-vector run.

## Interface
- `OUT_W`, 80: result width; matches `dut` `out[79:0]`.
- `CNT_W`, 16: width of the vector count and the mismatch counter.
- `POLY`, `80'h8000_0000_0000_0000_0025`: MISR feedback taps. Bit i set means it XORs the shifted-out MSB into bit i.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse. Latches `num_vec` and begins a run.
- `num_vec`  in  CNT_W  number of result beats in the run.
- `res_valid`  in  1  result beat present.
- `res_ready`  out  1  checker can accept a beat.
- `res_data`  in  OUT_W  `dut` output word.
- `exp_data`  in  OUT_W  expected word, qualified by `res_valid`.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete. Held high until the next `start` or `rst`.
- `pass`  out  1  valid only while `done` is high; 1 iff `mismatch_cnt == 0`.
- `mismatch_cnt`  out  CNT_W  failing beats; saturates at all-ones.
- `first_fail_idx`  out  CNT_W  beat index (from 0) of the first mismatch.
- `first_fail_xor`  out  OUT_W  `res_data ^ exp_data` of the first mismatch.
- `signature`  out  OUT_W  MISR state.

## Operation
- FSM states and transitions:
  - IDLE --start--> RUN. If `num_vec == 0`, IDLE --start--> DONE instead.
  - RUN --last beat checked--> DONE.
  - DONE --start--> RUN, or DONE --start--> DONE when `num_vec == 0`.
  - `start` is ignored while in RUN.
- On `start`, all of the following clear: `acc_cnt`, `chk_cnt`, `mismatch_cnt`, `first_fail_*`, `signature`, and the first-fail flag.
- `res_ready = (state == RUN) && (acc_cnt < num_vec_q)`.
- A beat transfers when `res_valid && res_ready`. On transfer, `acc_cnt` increments.
- Stage 1 is a register on transfer. It captures `s1_valid`, `s1_data = res_data`, `s1_xor = res_data ^ exp_data`, and `s1_idx = acc_cnt`.
- Stage 2 acts when `s1_valid` is set:
  - Updates the MISR: `signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? POLY : 0) ^ s1_data`.
  - `chk_cnt` increments.
  - If `|s1_xor`, `mismatch_cnt` increments with saturation. On the first mismatch only, it also latches `first_fail_idx = s1_idx` and `first_fail_xor = s1_xor`.
  - If `chk_cnt + 1 == num_vec_q`, the FSM moves to DONE.
- Ignored inputs:
  - `res_valid` while `res_ready` is low has no effect.
  - `res_data` and `exp_data` are don't-care without `res_valid`.

## Timing
- Reset values (async): state IDLE; every output 0, including `signature`, `pass`, and `res_ready`.
- Reset mid-run aborts the run immediately. No partial result is retained.
- Stage 1 behaviour:
  - Transfer at edge T makes stage 1 valid in cycle T..T+1.
  - Stage 1 accepts back-to-back beats at full throughput, 1 beat/cycle.
  - Stage 1 never stalls, since stage 2 is unconditional.
- Completion latency:
  - The final beat transferred at edge T is checked at edge T+1.
  - `done` and `pass` are high from T+1. `busy` and `res_ready` are low from T+1.
  - `res_ready` actually drops at edge T, because `acc_cnt` reaches `num_vec_q`.
- `num_vec == 0`: `done = 1` and `pass = 1` at the edge after `start`, with signature 0.
- `busy = (state == RUN)`.
- A new `start` in DONE clears `done` and `pass` at the next edge.
- Simultaneous `start` and `res_valid` in IDLE or DONE: no beat is accepted that cycle, because `res_ready` is still 0.
- `mismatch_cnt` at all-ones stays all-ones. `pass` remains 0.

## Structure
- Shared package `dut_chk_pkg` holds:
  - the `OUT_W` and `IN_W` (150) constants,
  - the default `POLY`,
  - the `chk_state_t` enum {IDLE, RUN, DONE}.
- One sub-module is natural: `misr_reg`, holding the MISR (clk, rst, clr, en, din, sig). Everything else stays in the top.

## Test plan
- Reset: assert `rst` mid-cycle during RUN with 3 of 8 beats accepted → all outputs 0 asynchronously. A subsequent `start` with `num_vec=2` completes normally.
- All-match run: `num_vec=4`, `res_data == exp_data` = {0, 1, 80'hFFFF…F, 2^79}, back-to-back → `done` one edge after the last transfer, `pass=1`, `mismatch_cnt=0`. `signature` equals the software MISR model.
- Mismatches: `num_vec=5`, beats 2 and 4 differ in bit 7 and bit 0 → `mismatch_cnt=2`, `first_fail_idx=2`, `first_fail_xor=80'h80`, `pass=0`.
- Backpressure and gaps: `res_valid` toggles 1,0,0,1,1 with `num_vec=3` → exactly 3 beats accepted. `res_ready` goes low after the third; a fourth `res_valid` pulse is ignored.
- Zero-length run: `start` with `num_vec=0` → `done=1`, `pass=1`, signature 0 on the next edge. A `start` during RUN is ignored; `num_vec_q` is unchanged.
- Saturation: `CNT_W=4`, `num_vec=15`, all mismatched, then rerun with `num_vec=15` after forcing the counter → `mismatch_cnt` holds at 15 and does not wrap.

Source files
------------

// File: rtl/dut_chk_pkg.sv
// Shared constants and FSM state type for the dut result checker.
// The checker consumes the 80-bit out word of the 150-bit-input dut vector stage.
package dut_chk_pkg;

    localparam int OUT_W = 80;
    localparam int IN_W  = 150;

    localparam logic [OUT_W-1:0] POLY = 80'h8000_0000_0000_0000_0025;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/dut_result_checker_misr.sv
// Multiple-input signature register compacting every checked result word.
// clr has priority over en so a new run always starts from a zero signature.
module misr_reg
    import dut_chk_pkg::*;
#(
    parameter int               W    = dut_chk_pkg::OUT_W,
    parameter logic [W-1:0]     POLY = dut_chk_pkg::POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_r;

    // Signature state: shift left, fold the outgoing MSB back through POLY, mix in din
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r <= {W{1'b0}};
        end else if (clr) begin
            sig_r <= {W{1'b0}};
        end else if (en) begin
            sig_r <= {sig_r[W-2:0], 1'b0} ^ (sig_r[W-1] ? POLY : {W{1'b0}}) ^ din;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/dut_result_checker.sv
// Streaming checker for dut result words: two-stage compare pipeline, mismatch
// counting with first-failure capture, and MISR compaction of every accepted word.
module dut_result_checker
    import dut_chk_pkg::*;
#(
    parameter int               OUT_W = dut_chk_pkg::OUT_W,
    parameter int               CNT_W = 16,
    parameter logic [OUT_W-1:0] POLY  = dut_chk_pkg::POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [OUT_W-1:0] res_data,
    input  logic [OUT_W-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0] first_fail_xor,
    output logic [OUT_W-1:0] signature
);

    chk_state_t       state_r, state_s;
    logic [CNT_W-1:0] num_vec_r, acc_cnt_r, chk_cnt_r;
    logic [CNT_W-1:0] mism_r, mism_s, ff_idx_r, s1_idx_r;
    logic [OUT_W-1:0] ff_xor_r, s1_data_r, s1_xor_r;
    logic             s1_valid_r, ff_seen_r, busy_r, done_r, pass_r;
    logic             start_s, ready_s, xfer_s, s1_fail_s, last_chk_s, pass_s;

    // Handshake decode, next-state and saturating mismatch-count logic
    always_comb begin
        start_s    = start && (state_r != RUN);
        ready_s    = (state_r == RUN) && (acc_cnt_r < num_vec_r);
        xfer_s     = res_valid && ready_s;
        s1_fail_s  = s1_valid_r && (s1_xor_r != {OUT_W{1'b0}});
        last_chk_s = s1_valid_r && ((chk_cnt_r + CNT_W'(1)) == num_vec_r);
        state_s    = state_r;
        mism_s     = mism_r;
        pass_s     = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = (num_vec == {CNT_W{1'b0}}) ? DONE : RUN;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (last_chk_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase

        if (start_s) begin
            mism_s = {CNT_W{1'b0}};
        end else if (s1_fail_s && (mism_r != {CNT_W{1'b1}})) begin
            mism_s = mism_r + CNT_W'(1);
        end else begin
            mism_s = mism_r;
        end

        if ((state_s == DONE) && (mism_s == {CNT_W{1'b0}})) begin
            pass_s = 1'b1;
        end else begin
            pass_s = 1'b0;
        end
    end

    // Run control, stage-1 capture and stage-2 bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            num_vec_r  <= {CNT_W{1'b0}};
            acc_cnt_r  <= {CNT_W{1'b0}};
            chk_cnt_r  <= {CNT_W{1'b0}};
            mism_r     <= {CNT_W{1'b0}};
            ff_idx_r   <= {CNT_W{1'b0}};
            ff_xor_r   <= {OUT_W{1'b0}};
            ff_seen_r  <= 1'b0;
            s1_valid_r <= 1'b0;
            s1_data_r  <= {OUT_W{1'b0}};
            s1_xor_r   <= {OUT_W{1'b0}};
            s1_idx_r   <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            mism_r  <= mism_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            pass_r  <= pass_s;
            if (start_s) begin
                num_vec_r  <= num_vec;
                acc_cnt_r  <= {CNT_W{1'b0}};
                chk_cnt_r  <= {CNT_W{1'b0}};
                ff_idx_r   <= {CNT_W{1'b0}};
                ff_xor_r   <= {OUT_W{1'b0}};
                ff_seen_r  <= 1'b0;
                s1_valid_r <= 1'b0;
            end else begin
                s1_valid_r <= xfer_s;
                if (xfer_s) begin
                    acc_cnt_r <= acc_cnt_r + CNT_W'(1);
                    s1_data_r <= res_data;
                    s1_xor_r  <= res_data ^ exp_data;
                    s1_idx_r  <= acc_cnt_r;
                end
                if (s1_valid_r) begin
                    chk_cnt_r <= chk_cnt_r + CNT_W'(1);
                end
                // Only the earliest failing beat is kept for debug
                if (s1_fail_s && !ff_seen_r) begin
                    ff_seen_r <= 1'b1;
                    ff_idx_r  <= s1_idx_r;
                    ff_xor_r  <= s1_xor_r;
                end
            end
        end
    end

    misr_reg #(
        .W    (OUT_W),
        .POLY (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_s),
        .en  (s1_valid_r),
        .din (s1_data_r),
        .sig (signature)
    );

    assign res_ready      = ready_s;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign mismatch_cnt   = mism_r;
    assign first_fail_idx = ff_idx_r;
    assign first_fail_xor = ff_xor_r;

endmodule
